wr_ctrl: RTL and testbench

Write-side controller for the asynchronous FIFO, the counterpart of the read-side FSM in the read clock domain. It accepts push requests in the write clock domain and generates the memory write enable and write address. It maintains the binary and Gray write pointers, synchronizes the read-domain Gray pointer, and produces registered full, almost-full and push-on-full error flags.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/wr_ctrl_if.sv | 30 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/wr_ctrl.sv | 89 ++++++++
 tb/tb_wr_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and width-generic Gray helpers.
// Used by both the write-side (wr_ctrl) and the read-side controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int FN_W        = 32;

  // Helpers work on a 32-bit container; callers pass their real width in w
  // and truncate the result back to that width.
  function automatic logic [FN_W-1:0] bin2gray(input int w, input logic [FN_W-1:0] b);
    logic [FN_W-1:0] mask;
    mask = (w >= FN_W) ? '1 : ((FN_W'(1) << w) - FN_W'(1));
    return (b ^ (b >> 1)) & mask;
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input int w, input logic [FN_W-1:0] g);
    logic [FN_W-1:0] r;
    r = '0;
    for (int i = 0; i < FN_W; i++) begin
      r[i] = (i < w) ? ^(g >> i) : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/wr_ctrl_if.sv
// Write-side FIFO bus: push request/accept, pointer exchange with the read domain, status flags.
// Handshake: push_fsm is a request; it is accepted (and memory written) in any cycle where
// wr_en_fsm is high, i.e. push_fsm & ~full_fsm. A rejected push is dropped, not held.
interface wr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
);
  logic              push_fsm;
  logic              clr_err_fsm;
  logic [ADDR_W:0]   rd_ptr_gray_fsm;
  logic              wr_en_fsm;
  logic [ADDR_W-1:0] wr_addr_fsm;
  logic [ADDR_W:0]   wr_ptr_gray_fsm;
  logic              full_fsm;
  logic              almost_full_fsm;
  logic              push_on_full_error_fsm;

  modport master (
    output push_fsm, clr_err_fsm, rd_ptr_gray_fsm,
    input  wr_en_fsm, wr_addr_fsm, wr_ptr_gray_fsm, full_fsm, almost_full_fsm,
           push_on_full_error_fsm
  );

  modport slave (
    input  push_fsm, clr_err_fsm, rd_ptr_gray_fsm,
    output wr_en_fsm, wr_addr_fsm, wr_ptr_gray_fsm, full_fsm, almost_full_fsm,
           push_on_full_error_fsm
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing clock domains; async active-low reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/wr_ctrl.sv
// Async-FIFO write-side controller: write pointers, synchronized read pointer, full/almost-full/error flags.
// Almost-full logic is only built when WR_CTRL_ALMOST_FULL_EN is defined; otherwise the flag is tied low.
module wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = 2
) (
  input  logic     wr_clk_fsm,
  input  logic     rst_n_in_wr_fsm,
  wr_ctrl_if.slave bus
);
  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
  logic [PTR_W-1:0] rq2;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             wr_en;

  sync_2ff #(.WIDTH(PTR_W)) u_rd_ptr_sync (
    .clk_i   (wr_clk_fsm),
    .rst_n_i (rst_n_in_wr_fsm),
    .d_i     (bus.rd_ptr_gray_fsm),
    .q_o     (rq2)
  );

  // Gated by reset so the write enable is low the instant reset asserts.
  assign wr_en = bus.push_fsm & ~full_q & rst_n_in_wr_fsm;

  always_comb begin
    wr_bin_d  = wr_bin_q + PTR_W'(wr_en);
    wr_gray_d = PTR_W'(bin2gray(PTR_W, 32'(wr_bin_d)));
    // Full when the next write pointer laps the synchronized read pointer by one depth.
    full_d    = (wr_gray_d == {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]});
    err_d     = err_q;
    if (bus.push_fsm && full_q) begin
      err_d = 1'b1;
    end else if (bus.clr_err_fsm) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk_fsm or negedge rst_n_in_wr_fsm) begin
    if (!rst_n_in_wr_fsm) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

`ifdef WR_CTRL_ALMOST_FULL_EN
  logic [PTR_W-1:0] fill;
  logic             af_q, af_d;

  always_comb begin
    fill = wr_bin_d - PTR_W'(gray2bin(PTR_W, 32'(rq2)));
    af_d = (fill >= PTR_W'(DEPTH - AF_THRESH));
  end

  always_ff @(posedge wr_clk_fsm or negedge rst_n_in_wr_fsm) begin
    if (!rst_n_in_wr_fsm) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign bus.almost_full_fsm = af_q;
`else
  logic af_cfg_unused;
  assign af_cfg_unused       = (AF_THRESH != DEPTH);
  assign bus.almost_full_fsm = 1'b0;
`endif

  assign bus.wr_en_fsm              = wr_en;
  assign bus.wr_addr_fsm            = wr_bin_q[ADDR_W-1:0];
  assign bus.wr_ptr_gray_fsm        = wr_gray_q;
  assign bus.full_fsm               = full_q;
  assign bus.push_on_full_error_fsm = err_q;
endmodule

// File: tb/tb_wr_ctrl.sv
// Self-checking bench for wr_ctrl: occupancy-based reference model driven by scenario tasks.
module tb_wr_ctrl;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
`ifdef WR_CTRL_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wr_ctrl_if #(.ADDR_W(AW)) bus ();

  wr_ctrl #(.ADDR_W(AW), .AF_THRESH(2)) dut (
    .wr_clk_fsm      (clk),
    .rst_n_in_wr_fsm (rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: write/read counts modulo 2*DEPTH and the two-edge-delayed view of the read count.
  int   wcnt, rd_cnt, rq1, rq2;
  logic m_full, m_af, m_err;
  logic obs_wr_en, exp_wr_en;
  logic [AW-1:0] obs_addr, exp_addr;
  logic [AW-1:0] exp_q[$];

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    wcnt = 0; rd_cnt = 0; rq1 = 0; rq2 = 0;
    m_full = 1'b0; m_af = 1'b0; m_err = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic drive_cycle(input logic p, input logic c);
    int f;
    bus.push_fsm        = p;
    bus.clr_err_fsm     = c;
    bus.rd_ptr_gray_fsm = PW'(gray_of(rd_cnt));
    @(negedge clk);
    obs_wr_en = bus.wr_en_fsm;
    obs_addr  = bus.wr_addr_fsm;
    exp_wr_en = p & ~m_full;
    exp_addr  = AW'(wcnt % DEPTH);
    @(posedge clk);
    if (p && m_full) m_err = 1'b1;
    else if (c)      m_err = 1'b0;
    if (exp_wr_en) wcnt = (wcnt + 1) % (2 * DEPTH);
    f      = (wcnt - rq2 + 2 * DEPTH) % (2 * DEPTH);
    m_full = (f == DEPTH);
    m_af   = AF_ON && (f >= DEPTH - 2);
    rq2    = rq1;
    rq1    = rd_cnt;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.push_fsm = 1'b0; bus.clr_err_fsm = 1'b0; bus.rd_ptr_gray_fsm = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.push_fsm = 1'b1; bus.clr_err_fsm = 1'b0; bus.rd_ptr_gray_fsm = '0;
    model_reset();
    #3;
    checks++; if (bus.wr_en_fsm !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.wr_en_fsm); end
    checks++; if (bus.wr_addr_fsm !== '0) begin errors++; $display("FAIL reset_addr got %0h exp 0", bus.wr_addr_fsm); end
    checks++; if (bus.wr_ptr_gray_fsm !== '0) begin errors++; $display("FAIL reset_gray got %0h exp 0", bus.wr_ptr_gray_fsm); end
    checks++; if ({bus.full_fsm, bus.almost_full_fsm, bus.push_on_full_error_fsm} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b%b%b exp 000", bus.full_fsm, bus.almost_full_fsm, bus.push_on_full_error_fsm);
    end
    bus.push_fsm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= DEPTH; k++) begin
      drive_cycle(1'b1, 1'b0);
      checks++; if (obs_wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr_en k=%0d got %b exp 1", k, obs_wr_en); end
      checks++; if (obs_addr !== AW'(k - 1)) begin errors++; $display("FAIL fill_addr k=%0d got %0d exp %0d", k, obs_addr, k - 1); end
      checks++; if (bus.full_fsm !== (k == DEPTH)) begin errors++; $display("FAIL fill_full k=%0d got %b exp %b", k, bus.full_fsm, k == DEPTH); end
      checks++; if (bus.almost_full_fsm !== (AF_ON && k >= 14)) begin
        errors++; $display("FAIL fill_af k=%0d got %b exp %b", k, bus.almost_full_fsm, AF_ON && k >= 14);
      end
    end
    checks++; if (bus.wr_ptr_gray_fsm !== 5'h18) begin errors++; $display("FAIL fill_gray got %0h exp 18", bus.wr_ptr_gray_fsm); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b0);
      checks++; if (obs_wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wr_en got %b exp 0", obs_wr_en); end
      checks++; if (obs_addr !== '0) begin errors++; $display("FAIL ovf_addr got %0d exp 0", obs_addr); end
      checks++; if (bus.push_on_full_error_fsm !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", bus.push_on_full_error_fsm); end
      checks++; if (bus.wr_ptr_gray_fsm !== 5'h18) begin errors++; $display("FAIL ovf_gray got %0h exp 18", bus.wr_ptr_gray_fsm); end
    end
    drive_cycle(1'b0, 1'b1);
    checks++; if (bus.push_on_full_error_fsm !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", bus.push_on_full_error_fsm); end
  endtask

  task automatic test_drain();
    int edges;
    edges  = 0;
    rd_cnt = 1;
    while (edges < 6 && bus.full_fsm === 1'b1) begin
      drive_cycle(1'b0, 1'b0);
      edges++;
    end
    checks++; if (edges !== 3) begin errors++; $display("FAIL drain_latency got %0d edges exp 3", edges); end
    checks++; if (bus.almost_full_fsm !== AF_ON) begin errors++; $display("FAIL drain_af got %b exp %b", bus.almost_full_fsm, AF_ON); end
    drive_cycle(1'b1, 1'b0);
    checks++; if (obs_wr_en !== 1'b1 || obs_addr !== '0) begin
      errors++; $display("FAIL drain_push got en=%b addr=%0d exp en=1 addr=0", obs_wr_en, obs_addr);
    end
    checks++; if (bus.full_fsm !== m_full) begin errors++; $display("FAIL drain_refull got %b exp %b", bus.full_fsm, m_full); end
  endtask

  task automatic test_wrap();
    int hist[$];
    int n, cyc, wraps;
    logic [AW-1:0] exp_a, prev_addr;
    logic [PW-1:0] prev_gray;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(AW'(i % DEPTH));
    n = 0; cyc = 0; wraps = 0; prev_addr = '0; prev_gray = '0;
    while (n < 40 && cyc < 200) begin
      hist.push_back(wcnt);
      if (hist.size() > 4) rd_cnt = hist.pop_front();
      drive_cycle(($urandom_range(0, 3) != 0), 1'b0);
      cyc++;
      checks++; if (obs_wr_en !== exp_wr_en) begin errors++; $display("FAIL wrap_wr_en got %b exp %b", obs_wr_en, exp_wr_en); end
      checks++; if (bus.full_fsm !== 1'b0) begin errors++; $display("FAIL wrap_full got %b exp 0", bus.full_fsm); end
      if (obs_wr_en === 1'b1) begin
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (obs_addr !== exp_a) begin errors++; $display("FAIL wrap_addr got %0d exp %0d", obs_addr, exp_a); end
        checks++; if ($countones(bus.wr_ptr_gray_fsm ^ prev_gray) != 1) begin
          errors++; $display("FAIL wrap_gray_step got %0h exp one-bit change from %0h", bus.wr_ptr_gray_fsm, prev_gray);
        end
        if (n > 0 && prev_addr == AW'(DEPTH - 1) && obs_addr == '0) wraps++;
        prev_addr = obs_addr;
        prev_gray = bus.wr_ptr_gray_fsm;
        n++;
      end
    end
    checks++; if (n != 40) begin errors++; $display("FAIL wrap_count got %0d writes exp 40", n); end
    checks++; if (wraps != 2) begin errors++; $display("FAIL wrap_wraps got %0d exp 2", wraps); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_queue got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int k = 0; k < DEPTH + 2; k++) drive_cycle(1'b1, 1'b0);
    checks++; if ({bus.full_fsm, bus.push_on_full_error_fsm} !== 2'b11) begin
      errors++; $display("FAIL mid_pre got full=%b err=%b exp 1 1", bus.full_fsm, bus.push_on_full_error_fsm);
    end
    bus.push_fsm = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({bus.wr_en_fsm, bus.full_fsm, bus.almost_full_fsm, bus.push_on_full_error_fsm} !== 4'b0000) begin
      errors++; $display("FAIL mid_flags got en=%b full=%b af=%b err=%b exp 0000", bus.wr_en_fsm, bus.full_fsm,
                         bus.almost_full_fsm, bus.push_on_full_error_fsm);
    end
    checks++; if ({bus.wr_addr_fsm, bus.wr_ptr_gray_fsm} !== '0) begin
      errors++; $display("FAIL mid_ptrs got addr=%0d gray=%0h exp 0 0", bus.wr_addr_fsm, bus.wr_ptr_gray_fsm);
    end
    bus.push_fsm = 1'b0; bus.rd_ptr_gray_fsm = '0;
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 1'b0);
    checks++; if (obs_wr_en !== 1'b1 || obs_addr !== '0) begin
      errors++; $display("FAIL mid_first_write got en=%b addr=%0d exp en=1 addr=0", obs_wr_en, obs_addr);
    end
  endtask

  task automatic test_random();
    logic p, c;
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 7) == 0);
      if (((wcnt - rd_cnt + 2 * DEPTH) % (2 * DEPTH)) > 0 && $urandom_range(0, 2) == 0)
        rd_cnt = (rd_cnt + 1) % (2 * DEPTH);
      drive_cycle(p, c);
      checks++; if (obs_wr_en !== exp_wr_en) begin errors++; $display("FAIL rnd_wr_en i=%0d got %b exp %b", i, obs_wr_en, exp_wr_en); end
      checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr i=%0d got %0d exp %0d", i, obs_addr, exp_addr); end
      checks++; if (bus.wr_ptr_gray_fsm !== PW'(gray_of(wcnt))) begin
        errors++; $display("FAIL rnd_gray i=%0d got %0h exp %0h", i, bus.wr_ptr_gray_fsm, gray_of(wcnt));
      end
      checks++; if (bus.full_fsm !== m_full) begin errors++; $display("FAIL rnd_full i=%0d got %b exp %b", i, bus.full_fsm, m_full); end
      checks++; if (bus.almost_full_fsm !== m_af) begin errors++; $display("FAIL rnd_af i=%0d got %b exp %b", i, bus.almost_full_fsm, m_af); end
      checks++; if (bus.push_on_full_error_fsm !== m_err) begin
        errors++; $display("FAIL rnd_err i=%0d got %b exp %b", i, bus.push_on_full_error_fsm, m_err);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
